joy_serial_rx: RTL and testbench
================================

Name: joy_serial_rx

Overview:
- Parametrised serial (shift-register) arcade joystick receiver for N players.
- Generates the load and clock strobes for an external parallel-in/serial-out adapter on the user port and deserialises the returned bit stream.
- Debounces each frame before committing it, and presents active-high per-player button words to the core's input-mapping logic.
- Successor to the fixed two-player DB15 reader: player count, bits per player, strobe rate, data polarity and debounce depth are all configurable.

Parameters:
- PLAYERS, 2: number of chained players, 1..4.
- BITS, 12: bits per player word, 1..16.
- CLK_DIV, 4: clk cycles per protocol tick, ≥2.
- DATA_ACTIVE_LOW, 1: 1 means joy_data low = pressed, and the output is inverted.
- DEBOUNCE, 2: consecutive identical frames required before commit, 1..7.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high.
- enable, in, 1: run frames while high.
- joy_data, in, 1: serial data from adapter; already synchronised by the caller.
- joy_clk, out, 1: shift clock to adapter.
- joy_load, out, 1: latch strobe to adapter, active-low.
- joystick, out, PLAYERS*BITS: committed buttons, active-high. Player p occupies bits [p*BITS +: BITS].
- valid, out, 1: one-cycle pulse on every commit.
- busy, out, 1: high while a frame is in progress (any state other than IDLE).

Behaviour:
- Reset values: joy_clk=1, joy_load=1, joystick=0, valid=0, busy=0. Prescaler, shift register, candidate word and match counter are cleared. FSM=IDLE.
- Reset mid-frame aborts the frame immediately; the partial frame is discarded.
- Prescaler: counts 0..CLK_DIV-1 and raises a one-cycle tick at CLK_DIV-1. It free-runs whenever not in reset. All FSM transitions occur only on tick.
- Frame length, with N=PLAYERS*BITS: 1 LOAD tick + 2*N shift ticks + 1 GAP tick.
- FSM states and transitions:
  - IDLE: joy_clk=1, joy_load=1. On tick with enable=1, go to LOAD.
  - LOAD: joy_load=0 for exactly one tick. Bit counter cleared. Go to CLK_LO.
  - CLK_LO: joy_clk=0. On the tick ending this state, sample joy_data into the shift register at index bitcnt. Go to CLK_HI.
  - CLK_HI: joy_clk=1. If bitcnt=N-1, go to GAP. Otherwise increment bitcnt and go to CLK_LO.
  - GAP: compare and commit (see below). Go to LOAD if enable=1, else IDLE.
- Bit order: the first sampled bit is player 0 bit 0; the last is player PLAYERS-1 bit BITS-1.
- Polarity: the frame word is the sampled bit XOR DATA_ACTIVE_LOW.
- Debounce, evaluated in GAP:
  - If frame == candidate, saturate-increment the match counter (3-bit).
  - Otherwise load candidate = frame and set the match counter to 1.
  - When the match counter reaches DEBOUNCE, write joystick = candidate and pulse valid for the cycle after the GAP tick.
  - Commit, and therefore valid, repeats every frame while the input is stable. Consumers must treat valid as "fresh sample", not "change".
- DEBOUNCE=1: every frame commits.
- enable dropped mid-frame: the current frame completes, including GAP and commit. The block then parks in IDLE, and joystick holds its last value.
- enable rising in IDLE: LOAD starts on the next tick, so start latency is at most CLK_DIV cycles.
- Widths: bitcnt is $clog2(N) bits (minimum 1). Its wrap is not used; the FSM terminates the count at N-1.

Decomposition:
- Package joy_serial_pkg holds:
  - the state enum typedef (IDLE, LOAD, CLK_LO, CLK_HI, GAP);
  - localparam MAX_PLAYERS=4;
  - localparam MAX_BITS=16;
  - a function frame_ticks(players, bits) returning the frame length in ticks.
- One sub-module, joy_serial_debounce: candidate/compare/commit logic, parametrised by width and DEBOUNCE. Inputs: frame word and frame_done strobe. Outputs: joystick and valid.
- The prescaler and FSM stay in the top module.

Test Plan:
- Defaults, reset held then released with enable=1 → joy_load low for cycles 4..7 (4 cycles wide). First joy_clk falling edge at cycle 8. Frame length 50 ticks = 200 cycles. Second joy_load low at cycle 204.
- Adapter model drives player 0 = 12'hFFE (bit 0 low = pressed) and player 1 = 12'hFFF on two consecutive frames → joystick=24'h000001 and valid pulses once, one cycle after the 2nd GAP tick. No commit after the 1st frame.
- Glitch: frames A, B, A with A≠B and DEBOUNCE=2 → no commit during the glitch. The commit of A happens only after two consecutive A frames.
- enable deasserted at cycle 100 (mid-shift) → the frame completes, then joy_clk=1 and joy_load=1 are held. busy falls after GAP, and joystick holds its value.
- reset pulsed at mid-frame (cycle 150) → all outputs return to reset values in the next cycle. The next joy_load low begins CLK_DIV cycles after reset release.
- PLAYERS=4, BITS=16, DATA_ACTIVE_LOW=0, DEBOUNCE=1, with stream 64'hDEADBEEF_01234567 (LSB first) → joystick equals that value after one frame, and valid fires every frame (every 130 ticks).

Source files
------------

// File: rtl/joy_serial_pkg.sv
// -----------------------------------------------------------------------------
// joy_serial_pkg
// Shared definitions for the serial arcade joystick receiver:
//   - state_t      : frame sequencer states
//   - MAX_PLAYERS  : largest supported player chain
//   - MAX_BITS     : largest supported word per player
//   - MATCH_W/MAX  : width and saturation value of the debounce match counter
//   - frame_ticks(): protocol ticks taken by one complete frame
// No ports (package).
// -----------------------------------------------------------------------------
package joy_serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        CLK_LO = 3'd2,
        CLK_HI = 3'd3,
        GAP    = 3'd4
    } state_t;

    localparam int MAX_PLAYERS = 4;
    localparam int MAX_BITS    = 16;

    localparam int                 MATCH_W   = 3;
    localparam logic [MATCH_W-1:0] MATCH_MAX = 3'b111;

    // One LOAD tick, a low and a high tick per bit, then one GAP tick.
    function automatic int frame_ticks(input int players, input int bits);
        return 2 * players * bits + 2;
    endfunction

endpackage

// File: rtl/joy_serial_rx_if.sv
// -----------------------------------------------------------------------------
// joy_serial_rx_if
// Bundles the adapter link and the core-facing button outputs of the receiver.
//   enable   : run frames while high (core -> receiver)
//   joy_data : serial data from the adapter (adapter -> receiver)
//   joy_clk  : shift clock to the adapter (receiver -> adapter)
//   joy_load : active-low latch strobe to the adapter (receiver -> adapter)
//   joystick : committed active-high buttons, W bits (receiver -> core)
//   valid    : one-cycle pulse per commit (receiver -> core)
//   busy     : high while a frame is in progress (receiver -> core)
// master = receiver side, slave = core/adapter side.
// -----------------------------------------------------------------------------
interface joy_serial_rx_if #(
    parameter int W = 24
);
    logic         enable;
    logic         joy_data;
    logic         joy_clk;
    logic         joy_load;
    logic [W-1:0] joystick;
    logic         valid;
    logic         busy;

    modport master (
        input  enable,
        input  joy_data,
        output joy_clk,
        output joy_load,
        output joystick,
        output valid,
        output busy
    );

    modport slave (
        output enable,
        output joy_data,
        input  joy_clk,
        input  joy_load,
        input  joystick,
        input  valid,
        input  busy
    );
endinterface

// File: rtl/joy_serial_debounce.sv
// -----------------------------------------------------------------------------
// joy_serial_debounce
// Holds a candidate frame and counts how many consecutive frames matched it.
// Once the count reaches DEBOUNCE the candidate is committed to joystick and
// valid pulses; this repeats on every further matching frame.
//   clk, reset : system clock, synchronous active-high reset
//   frame      : completed frame word (W bits, already active-high)
//   frame_done : one-cycle strobe marking frame as complete
//   joystick   : committed word (registered)
//   valid      : one-cycle commit pulse (registered)
// -----------------------------------------------------------------------------
module joy_serial_debounce
    import joy_serial_pkg::*;
#(
    parameter int W        = 24,
    parameter int DEBOUNCE = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] frame,
    input  logic         frame_done,
    output logic [W-1:0] joystick,
    output logic         valid
);

    logic [W-1:0]       cand_r;
    logic [MATCH_W-1:0] match_r;
    logic [W-1:0]       joystick_r;
    logic               valid_r;
    logic [MATCH_W-1:0] match_nxt_s;
    logic               commit_s;

    // Next match count and commit decision for the frame currently offered.
    always_comb begin
        match_nxt_s = match_r;
        commit_s    = 1'b0;
        if (frame == cand_r) begin
            if (match_r == MATCH_MAX) begin
                match_nxt_s = MATCH_MAX;
            end else begin
                match_nxt_s = match_r + 3'd1;
            end
        end else begin
            match_nxt_s = 3'd1;
        end
        // Greater-or-equal so a saturated run keeps committing every frame.
        commit_s = (match_nxt_s >= MATCH_W'(DEBOUNCE));
    end

    // Candidate, match counter and committed outputs, updated once per frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            cand_r     <= {W{1'b0}};
            match_r    <= 3'd0;
            joystick_r <= {W{1'b0}};
            valid_r    <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (frame_done) begin
                cand_r  <= frame;
                match_r <= match_nxt_s;
                if (commit_s) begin
                    // Candidate after this update equals frame.
                    joystick_r <= frame;
                    valid_r    <= 1'b1;
                end
            end
        end
    end

    assign joystick = joystick_r;
    assign valid    = valid_r;

endmodule

// File: rtl/joy_serial_rx.sv
// -----------------------------------------------------------------------------
// joy_serial_rx
// Serial (PISO shift-register) arcade joystick receiver for PLAYERS players of
// BITS buttons each. A free-running prescaler produces a protocol tick every
// CLK_DIV clocks; the frame sequencer pulses joy_load, clocks 2*N half-periods
// on joy_clk while sampling joy_data, then hands the frame to the debouncer.
//   clk   : system clock
//   reset : synchronous, active-high; aborts any frame in progress
//   bus   : joy_serial_rx_if.master (enable, joy_data in; joy_clk, joy_load,
//           joystick, valid, busy out). Player p is joystick[p*BITS +: BITS].
// -----------------------------------------------------------------------------
module joy_serial_rx
    import joy_serial_pkg::*;
#(
    parameter int PLAYERS         = 2,
    parameter int BITS            = 12,
    parameter int CLK_DIV         = 4,
    parameter int DATA_ACTIVE_LOW = 1,
    parameter int DEBOUNCE        = 2
) (
    input  logic            clk,
    input  logic            reset,
    joy_serial_rx_if.master bus
);

    localparam int   N     = PLAYERS * BITS;
    localparam int   CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int   PRE_W = $clog2(CLK_DIV);
    localparam logic POL   = (DATA_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic [PRE_W-1:0] presc_r;
    logic             tick_s;
    state_t           state_r;
    logic [CNT_W-1:0] bitcnt_r;
    logic [N-1:0]     shift_r;
    logic             joy_clk_r;
    logic             joy_load_r;
    logic             busy_r;
    logic             frame_done_s;
    logic [N-1:0]     joystick_s;
    logic             valid_s;

    assign tick_s       = (presc_r == PRE_W'(CLK_DIV - 1));
    assign frame_done_s = tick_s && (state_r == GAP);

    // Prescaler: free-running 0..CLK_DIV-1, tick on the last count.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_r <= {PRE_W{1'b0}};
        end else if (tick_s) begin
            presc_r <= {PRE_W{1'b0}};
        end else begin
            presc_r <= presc_r + PRE_W'(1);
        end
    end

    // Frame sequencer with registered strobes; advances only on tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            bitcnt_r   <= {CNT_W{1'b0}};
            shift_r    <= {N{1'b0}};
            joy_clk_r  <= 1'b1;
            joy_load_r <= 1'b1;
            busy_r     <= 1'b0;
        end else if (tick_s) begin
            case (state_r)
                IDLE: begin
                    if (bus.enable) begin
                        state_r    <= LOAD;
                        joy_load_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r    <= IDLE;
                        joy_load_r <= 1'b1;
                        joy_clk_r  <= 1'b1;
                        busy_r     <= 1'b0;
                    end
                end
                LOAD: begin
                    bitcnt_r   <= {CNT_W{1'b0}};
                    joy_load_r <= 1'b1;
                    joy_clk_r  <= 1'b0;
                    state_r    <= CLK_LO;
                end
                CLK_LO: begin
                    // Sample at the end of the low phase, before the rising
                    // edge shifts the adapter to its next bit.
                    shift_r[bitcnt_r] <= bus.joy_data ^ POL;
                    joy_clk_r         <= 1'b1;
                    state_r           <= CLK_HI;
                end
                CLK_HI: begin
                    if (bitcnt_r == CNT_W'(N - 1)) begin
                        state_r <= GAP;
                    end else begin
                        bitcnt_r  <= bitcnt_r + CNT_W'(1);
                        joy_clk_r <= 1'b0;
                        state_r   <= CLK_LO;
                    end
                end
                GAP: begin
                    // Debouncer consumes shift_r on this tick via frame_done_s.
                    if (bus.enable) begin
                        state_r    <= LOAD;
                        joy_load_r <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    joy_clk_r  <= 1'b1;
                    joy_load_r <= 1'b1;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    joy_serial_debounce #(
        .W        (N),
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk        (clk),
        .reset      (reset),
        .frame      (shift_r),
        .frame_done (frame_done_s),
        .joystick   (joystick_s),
        .valid      (valid_s)
    );

    assign bus.joy_clk  = joy_clk_r;
    assign bus.joy_load = joy_load_r;
    assign bus.busy     = busy_r;
    assign bus.joystick = joystick_s;
    assign bus.valid    = valid_s;

endmodule

// File: tb/tb_joy_serial_rx.sv
// -----------------------------------------------------------------------------
// tb_joy_serial_rx
// Directed bench for joy_serial_rx. dut_a uses the default parameters
// (2x12 bits, active-low data, DEBOUNCE=2); dut_b uses 4x16 bits, active-high
// data, DEBOUNCE=1. Each DUT is fed by a small PISO adapter model that latches
// a frame word on the falling edge of joy_load and advances one bit per rising
// edge of joy_clk. Cycle k of dut_a is the k-th clock period after its reset
// release; dut_b is released at cycle 2000.
// -----------------------------------------------------------------------------
module tb_joy_serial_rx;
    import joy_serial_pkg::*;

    localparam int CYC_A = 4 * frame_ticks(2, 12);  // 200 clocks per frame
    localparam int CYC_B = 4 * frame_ticks(4, 16);  // 520 clocks per frame
    localparam int B0    = 2000;                    // dut_b reset release cycle

    localparam logic [23:0] A0 = 24'h000001;
    localparam logic [23:0] A2 = 24'h800C35;
    localparam logic [23:0] BB = 24'h123456;
    localparam logic [63:0] S0 = 64'hDEADBEEF_01234567;
    localparam logic [63:0] S1 = 64'h01234567_89ABCDEF;

    logic clk = 1'b0;
    logic reset_a;
    logic reset_b;
    int   tests  = 0;
    int   fails  = 0;
    int   cyc    = 0;
    int   vcnt_a = 0;

    always #5 clk = ~clk;

    joy_serial_rx_if #(.W(24)) if_a ();
    joy_serial_rx_if #(.W(64)) if_b ();

    joy_serial_rx dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (if_a)
    );

    joy_serial_rx #(
        .PLAYERS         (4),
        .BITS            (16),
        .CLK_DIV         (4),
        .DATA_ACTIVE_LOW (0),
        .DEBOUNCE        (1)
    ) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (if_b)
    );

    // Intended (active-high) button words for each successive frame of dut_a.
    function automatic logic [23:0] frame_a(input int n);
        case (n)
            0, 1:    return A0;
            2:       return A2;
            3:       return BB;
            default: return A2;
        endcase
    endfunction

    function automatic logic [63:0] frame_b(input int n);
        case (n)
            0:       return S0;
            default: return S1;
        endcase
    endfunction

    // Adapter model for dut_a: data is active-low on the wire.
    logic [63:0] word_a = 64'hFFFF_FFFF_FFFF_FFFF;
    logic [5:0]  idx_a  = 6'd0;
    int          fidx_a = 0;
    always @(negedge if_a.joy_load or posedge if_a.joy_clk) begin
        if (if_a.joy_load == 1'b0) begin
            word_a = {40'hFF_FFFF_FFFF, ~frame_a(fidx_a)};
            fidx_a = fidx_a + 1;
            idx_a  = 6'd0;
        end else begin
            idx_a = idx_a + 6'd1;
        end
    end
    assign if_a.joy_data = word_a[idx_a];

    // Adapter model for dut_b: data is active-high on the wire.
    logic [63:0] word_b = 64'h0;
    logic [5:0]  idx_b  = 6'd0;
    int          fidx_b = 0;
    always @(negedge if_b.joy_load or posedge if_b.joy_clk) begin
        if (if_b.joy_load == 1'b0) begin
            word_b = frame_b(fidx_b);
            fidx_b = fidx_b + 1;
            idx_b  = 6'd0;
        end else begin
            idx_b = idx_b + 6'd1;
        end
    end
    assign if_b.joy_data = word_b[idx_b];

    // Count valid pulses of dut_a, sampled mid-cycle.
    always @(negedge clk) begin
        if (if_a.valid === 1'b1) vcnt_a = vcnt_a + 1;
    end

    // Advance to 1 time unit after the start of cycle k.
    task automatic goto(input int k);
        while (cyc < k) begin
            @(posedge clk);
            cyc = cyc + 1;
        end
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_a     = 1'b1;
        reset_b     = 1'b1;
        if_a.enable = 1'b1;
        if_b.enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_a = 1'b0;
        cyc     = 0;

        // Reset state and first-frame strobe timing.
        goto(0);
        chk("a_rst_load",  64'(if_a.joy_load), 64'd1);
        chk("a_rst_clk",   64'(if_a.joy_clk),  64'd1);
        chk("a_rst_busy",  64'(if_a.busy),     64'd0);
        chk("a_rst_valid", 64'(if_a.valid),    64'd0);
        chk("a_rst_joy",   64'(if_a.joystick), 64'd0);
        goto(3);
        chk("a_load_c3",   64'(if_a.joy_load), 64'd1);
        goto(4);
        chk("a_load_c4",   64'(if_a.joy_load), 64'd0);
        chk("a_busy_c4",   64'(if_a.busy),     64'd1);
        goto(7);
        chk("a_load_c7",   64'(if_a.joy_load), 64'd0);
        chk("a_clk_c7",    64'(if_a.joy_clk),  64'd1);
        goto(8);
        chk("a_load_c8",   64'(if_a.joy_load), 64'd1);
        chk("a_clk_c8",    64'(if_a.joy_clk),  64'd0);
        goto(12);
        chk("a_clk_c12",   64'(if_a.joy_clk),  64'd1);
        goto(CYC_A + 3);
        chk("a_load_c203", 64'(if_a.joy_load), 64'd1);

        // First frame only seeds the candidate; second identical frame commits.
        goto(CYC_A + 4);
        chk("a_load_c204", 64'(if_a.joy_load), 64'd0);
        chk("a_valid_f0",  64'(if_a.valid),    64'd0);
        chk("a_joy_f0",    64'(if_a.joystick), 64'd0);
        chk("a_vcnt_f0",   64'(vcnt_a),        64'd0);
        goto(2 * CYC_A + 4);
        chk("a_valid_f1",  64'(if_a.valid),    64'd1);
        chk("a_joy_f1",    64'(if_a.joystick), 64'(A0));
        goto(2 * CYC_A + 5);
        chk("a_valid_405", 64'(if_a.valid),    64'd0);
        chk("a_vcnt_f1",   64'(vcnt_a),        64'd1);

        // Glitch A2, B, A2: nothing commits until the second consecutive A2.
        goto(6 * CYC_A + 3);
        chk("a_vcnt_glitch", 64'(vcnt_a),        64'd1);
        chk("a_joy_glitch",  64'(if_a.joystick), 64'(A0));
        goto(6 * CYC_A + 4);
        chk("a_valid_f5",    64'(if_a.valid),    64'd1);
        chk("a_joy_f5",      64'(if_a.joystick), 64'(A2));

        // Drop enable mid-shift: frame completes, commits, then parks in IDLE.
        goto(1300);
        if_a.enable = 1'b0;
        goto(7 * CYC_A + 3);
        chk("a_busy_1403",  64'(if_a.busy),     64'd1);
        goto(7 * CYC_A + 4);
        chk("a_busy_1404",  64'(if_a.busy),     64'd0);
        chk("a_valid_f6",   64'(if_a.valid),    64'd1);
        chk("a_load_1404",  64'(if_a.joy_load), 64'd1);
        chk("a_clk_1404",   64'(if_a.joy_clk),  64'd1);
        goto(1500);
        chk("a_load_idle",  64'(if_a.joy_load), 64'd1);
        chk("a_clk_idle",   64'(if_a.joy_clk),  64'd1);
        chk("a_busy_idle",  64'(if_a.busy),     64'd0);
        chk("a_joy_idle",   64'(if_a.joystick), 64'(A2));
        chk("a_vcnt_idle",  64'(vcnt_a),        64'd3);

        // Re-enable in IDLE: LOAD on the next tick.
        if_a.enable = 1'b1;
        goto(1503);
        chk("a_load_1503",  64'(if_a.joy_load), 64'd1);
        goto(1504);
        chk("a_load_1504",  64'(if_a.joy_load), 64'd0);

        // Reset mid-frame: outputs clear next cycle, restart CLK_DIV later.
        goto(1550);
        chk("a_busy_1550",  64'(if_a.busy),     64'd1);
        reset_a = 1'b1;
        goto(1551);
        chk("a_mrst_load",  64'(if_a.joy_load), 64'd1);
        chk("a_mrst_clk",   64'(if_a.joy_clk),  64'd1);
        chk("a_mrst_busy",  64'(if_a.busy),     64'd0);
        chk("a_mrst_valid", 64'(if_a.valid),    64'd0);
        chk("a_mrst_joy",   64'(if_a.joystick), 64'd0);
        reset_a = 1'b0;
        goto(1554);
        chk("a_load_1554",  64'(if_a.joy_load), 64'd1);
        goto(1555);
        chk("a_load_1555",  64'(if_a.joy_load), 64'd0);
        goto(1555 + CYC_A);
        chk("a_valid_pr1",  64'(if_a.valid),    64'd0);
        chk("a_joy_pr1",    64'(if_a.joystick), 64'd0);
        goto(1555 + 2 * CYC_A);
        chk("a_valid_pr2",  64'(if_a.valid),    64'd1);
        chk("a_joy_pr2",    64'(if_a.joystick), 64'(A2));

        // dut_b: 4x16, active-high data, every frame commits.
        goto(B0);
        chk("b_rst_load",   64'(if_b.joy_load), 64'd1);
        chk("b_rst_clk",    64'(if_b.joy_clk),  64'd1);
        chk("b_rst_valid",  64'(if_b.valid),    64'd0);
        chk("b_rst_joy",    if_b.joystick,      64'd0);
        reset_b = 1'b0;
        goto(B0 + 4);
        chk("b_load_c4",    64'(if_b.joy_load), 64'd0);
        goto(B0 + CYC_B + 3);
        chk("b_valid_pre",  64'(if_b.valid),    64'd0);
        chk("b_joy_pre",    if_b.joystick,      64'd0);
        goto(B0 + CYC_B + 4);
        chk("b_valid_f0",   64'(if_b.valid),    64'd1);
        chk("b_joy_f0",     if_b.joystick,      S0);
        goto(B0 + CYC_B + 5);
        chk("b_valid_post", 64'(if_b.valid),    64'd0);
        goto(B0 + 2 * CYC_B + 4);
        chk("b_valid_f1",   64'(if_b.valid),    64'd1);
        chk("b_joy_f1",     if_b.joystick,      S1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
